// File: rtl/transpose_pkg.sv
// Shared types and sizing helpers for the column-to-row transpose block.
// Bank index is one bit: the BRAM holds exactly two frames.
package transpose_pkg;

    typedef enum logic [0:0] {IDLE, RUN} rd_state_t;

    typedef logic bank_t;

    function automatic int addr_width(input int w, input int h);
        return $clog2(2 * w * h);
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bram_wrapper.sv
// Simple dual-port BRAM: one write port, one read port, 1-cycle registered read.
// No flow control; caller owns address/enable sequencing.
module bram_wrapper #(
    parameter int depth      = 16,
    parameter int data_width = 8,
    parameter int addr_width = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [addr_width-1:0] wr_addr,
    input  logic [data_width-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [addr_width-1:0] rd_addr,
    output logic [data_width-1:0] rd_data
);

    logic [data_width-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/out_skid_buffer.sv
// 2-entry ready/valid register pair; output comes straight from a register, held while stalled.
// Never refuses a push: the producer must keep count plus its in-flight words at or below 2.
module out_skid_buffer #(
    parameter int payload_width = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [payload_width-1:0] in_data,
    output logic                     out_valid,
    output logic [payload_width-1:0] out_data,
    input  logic                     out_ready,
    output logic [1:0]               count
);

    logic [payload_width-1:0] slot [2];
    logic                     wr_ptr;
    logic                     rd_ptr;
    logic                     push;
    logic                     pop;

    assign push      = in_valid;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = slot[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= in_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/transpose_col_to_row.sv
// Column-major in, row-major out via a ping-pong BRAM; first word 4 edges after a frame's last input.
// Input has no backpressure (full bank drops a frame, sticky overflow); output is ready/valid. Option: TRANSPOSE_FRAME_MARKERS_EN.
module transpose_col_to_row
    import transpose_pkg::*;
#(
    parameter int width      = 120,
    parameter int height     = 240,
    parameter int data_width = 21
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [data_width-1:0] in_data,
    input  logic                  in_valid,
    output logic [data_width-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow
`ifdef TRANSPOSE_FRAME_MARKERS_EN
    ,
    output logic                  out_sof,
    output logic                  out_eol
`endif
);

    localparam int FRAME = width * height;
    localparam int AW    = addr_width(width, height);
    localparam int RW    = cnt_width(height);
    localparam int CW    = cnt_width(width);
`ifdef TRANSPOSE_FRAME_MARKERS_EN
    localparam int PW    = data_width + 2;
`else
    localparam int PW    = data_width;
`endif

    localparam logic [RW-1:0] ROW_LAST   = RW'(height - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(width - 1);
    localparam logic [AW-1:0] LIN_LAST   = AW'(FRAME - 1);
    localparam logic [AW-1:0] BANK1_BASE = AW'(FRAME);
    localparam logic [AW-1:0] ROW_STEP   = AW'(width);

    logic [1:0]            bank_full;
    logic [RW-1:0]         wr_row;
    logic [CW-1:0]         wr_col;
    logic [AW-1:0]         wr_lin;
    bank_t                 wr_bank;
    logic                  frame_drop;
    logic                  wr_en_q;
    logic [AW-1:0]         wr_addr_q;
    logic [data_width-1:0] wr_data_q;
    logic                  set_full_q;
    bank_t                 set_bank_q;
    logic                  wr_first;
    logic                  wr_last;
    logic                  full_eff;
    logic                  drop_now;

    rd_state_t             state;
    rd_state_t             next_state;
    logic [AW-1:0]         rd_lin;
    bank_t                 rd_bank;
    logic                  rd_issue;
    logic                  rd_release;
    logic [AW-1:0]         rd_addr;
    logic                  bram_vld;
    logic [data_width-1:0] bram_rd_data;
    logic [1:0]            skid_cnt;
    logic [2:0]            occ;
    logic [PW-1:0]         skid_in;
    logic [PW-1:0]         skid_out;

    assign wr_first = (wr_row == '0) && (wr_col == '0);
    assign wr_last  = (wr_row == ROW_LAST) && (wr_col == COL_LAST);
    // A release landing on the bank being checked frees it in time for this frame.
    assign full_eff = bank_full[wr_bank] && !(rd_release && (rd_bank == wr_bank));
    assign drop_now = wr_first ? full_eff : frame_drop;

    // Writes are staged one cycle; bank_full rises with the last word's memory write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_row     <= '0;
            wr_col     <= '0;
            wr_lin     <= '0;
            wr_bank    <= 1'b0;
            frame_drop <= 1'b0;
            overflow   <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            set_full_q <= 1'b0;
            set_bank_q <= 1'b0;
        end else begin
            wr_en_q    <= in_valid && !drop_now;
            set_full_q <= in_valid && wr_last && !drop_now;
            set_bank_q <= wr_bank;
            wr_addr_q  <= (wr_bank ? BANK1_BASE : '0) + wr_lin;
            wr_data_q  <= in_data;
            if (in_valid) begin
                if (wr_first) frame_drop <= full_eff;
                if (wr_first && full_eff) overflow <= 1'b1;
                if (wr_last && !drop_now) wr_bank <= ~wr_bank;
                if (wr_row == ROW_LAST) begin
                    wr_row <= '0;
                    if (wr_col == COL_LAST) begin
                        wr_col <= '0;
                        wr_lin <= '0;
                    end else begin
                        wr_col <= wr_col + CW'(1);
                        wr_lin <= AW'(wr_col) + AW'(1);
                    end
                end else begin
                    wr_row <= wr_row + RW'(1);
                    wr_lin <= wr_lin + ROW_STEP;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_full <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (rd_release && (rd_bank == bank_t'(b))) bank_full[b] <= 1'b0;
                if (set_full_q && (set_bank_q == bank_t'(b))) bank_full[b] <= 1'b1;
            end
        end
    end

    // Occupancy as it will stand after this edge's pop, so reads stream at full rate.
    assign occ     = {1'b0, skid_cnt} - {2'b00, out_valid && out_ready} + {2'b00, bram_vld};
    assign rd_addr = (rd_bank ? BANK1_BASE : '0) + rd_lin;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        rd_issue   = 1'b0;
        rd_release = 1'b0;
        unique case (state)
            IDLE: if (bank_full[rd_bank]) next_state = RUN;
            RUN: begin
                if (occ < 3'd2) begin
                    rd_issue = 1'b1;
                    if (rd_lin == LIN_LAST) begin
                        rd_release = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_lin   <= '0;
            rd_bank  <= 1'b0;
            bram_vld <= 1'b0;
        end else begin
            bram_vld <= rd_issue;
            if (rd_issue) rd_lin <= rd_release ? '0 : rd_lin + AW'(1);
            if (rd_release) rd_bank <= ~rd_bank;
        end
    end

    bram_wrapper #(
        .depth      (2 * FRAME),
        .data_width (data_width),
        .addr_width (AW)
    ) u_bram (
        .clk     (clk),
        .wr_en   (wr_en_q),
        .wr_addr (wr_addr_q),
        .wr_data (wr_data_q),
        .rd_en   (rd_issue),
        .rd_addr (rd_addr),
        .rd_data (bram_rd_data)
    );

`ifdef TRANSPOSE_FRAME_MARKERS_EN
    logic [CW-1:0] rd_col;
    logic          sof_q;
    logic          eol_q;

    // Markers ride one cycle behind the address, matching the BRAM read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_col <= '0;
            sof_q  <= 1'b0;
            eol_q  <= 1'b0;
        end else if (rd_issue) begin
            sof_q  <= (rd_lin == '0);
            eol_q  <= (rd_col == COL_LAST);
            rd_col <= (rd_col == COL_LAST) ? '0 : rd_col + CW'(1);
        end
    end

    assign skid_in  = {sof_q, eol_q, bram_rd_data};
    assign out_sof  = skid_out[PW-1];
    assign out_eol  = skid_out[PW-2];
`else
    assign skid_in  = bram_rd_data;
`endif
    assign out_data = skid_out[data_width-1:0];

    out_skid_buffer #(
        .payload_width (PW)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (bram_vld),
        .in_data   (skid_in),
        .out_valid (out_valid),
        .out_data  (skid_out),
        .out_ready (out_ready),
        .count     (skid_cnt)
    );

endmodule

// File: tb/tb_transpose_col_to_row.sv
// Directed bench for transpose_col_to_row at width=4, height=3, data_width=8.
// Input word = base + col*16 + row; row-major order expected on the output.
module tb_transpose_col_to_row;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          overflow;
`ifdef TRANSPOSE_FRAME_MARKERS_EN
    logic          out_sof;
    logic          out_eol;
    logic          sof_q[$];
    logic          eol_q[$];
`endif

    int checks = 0;
    int failures = 0;

    bit rdy_toggle = 1'b0;
    bit rdy_level = 1'b0;
    bit mon_en = 1'b0;
    int edge_cnt = 0;
    int last_acc = 0;
    int first_vld = -1;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_dat = '0;
    logic [DW-1:0] got_q[$];

    always #5 clk = ~clk;

    transpose_col_to_row #(
        .width      (W),
        .height     (H),
        .data_width (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
`ifdef TRANSPOSE_FRAME_MARKERS_EN
        ,
        .out_sof   (out_sof),
        .out_eol   (out_eol)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Consumer ready: either held at rdy_level or toggling every cycle.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_toggle ? ~out_ready : rdy_level;
        end
    end

    // Output monitor; negedge count equals the number of rising edges so far.
    initial begin
        forever begin
            @(negedge clk);
            edge_cnt++;
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (in_valid) last_acc = edge_cnt + 1;
                if (out_valid && first_vld < 0) first_vld = edge_cnt;
                if (mon_en && prev_stall) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data", 32'(out_data), 32'(prev_dat));
                end
                if (mon_en && out_valid && out_ready) begin
                    got_q.push_back(out_data);
`ifdef TRANSPOSE_FRAME_MARKERS_EN
                    sof_q.push_back(out_sof);
                    eol_q.push_back(out_eol);
`endif
                end
                prev_stall = out_valid && !out_ready;
                prev_dat   = out_data;
            end
        end
    end

    task automatic send_frame(input logic [DW-1:0] base, input int n);
        int k = 0;
        for (int c = 0; c < W; c++) begin
            for (int r = 0; r < H; r++) begin
                if (k < n) begin
                    @(posedge clk);
                    #1;
                    in_valid = 1'b1;
                    in_data  = base + DW'(c * 16 + r);
                    k++;
                end
            end
        end
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget, input int settle);
        int t = 0;
        while (got_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        repeat (settle) @(negedge clk);
    endtask

    task automatic expect_frame(input string tag, input logic [DW-1:0] base, input int start);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int idx = start + r * W + c;
                if (idx < got_q.size())
                    check(tag, 32'(got_q[idx]), 32'(base + DW'(c * 16 + r)));
            end
        end
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single frame, out_ready held high
        rdy_level = 1'b1;
        repeat (3) @(negedge clk);
        got_q.delete();
        first_vld = -1;
        mon_en = 1'b1;
        send_frame(8'h00, W * H);
        go_idle();
        wait_words(W * H, 60, 20);
        check("single_count", 32'(got_q.size()), 32'(W * H));
        expect_frame("single_word", 8'h00, 0);
        check("single_latency", 32'(first_vld - last_acc), 32'd4);
        check("single_overflow", 32'(overflow), 32'd0);
`ifdef TRANSPOSE_FRAME_MARKERS_EN
        for (int i = 0; i < sof_q.size(); i++) begin
            check("marker_sof", 32'(sof_q[i]), 32'(i == 0));
            check("marker_eol", 32'(eol_q[i]), 32'((i % W) == W - 1));
        end
`endif

        // Backpressure: ready alternates every cycle
        got_q.delete();
        rdy_toggle = 1'b1;
        send_frame(8'h00, W * H);
        go_idle();
        wait_words(W * H, 100, 20);
        rdy_level = 1'b1;
        rdy_toggle = 1'b0;
        check("bp_count", 32'(got_q.size()), 32'(W * H));
        expect_frame("bp_word", 8'h00, 0);

        // Overflow: three frames back to back with the consumer stalled
        rdy_level = 1'b0;
        repeat (3) @(negedge clk);
        got_q.delete();
        send_frame(8'h00, W * H);
        send_frame(8'h40, W * H);
        @(negedge clk);
        check("ovf_before", 32'(overflow), 32'd0);
        send_frame(8'h80, W * H);
        go_idle();
        repeat (3) @(negedge clk);
        check("ovf_after", 32'(overflow), 32'd1);
        check("ovf_stalled_valid", 32'(out_valid), 32'd1);
        rdy_level = 1'b1;
        wait_words(2 * W * H, 120, 40);
        check("ovf_count", 32'(got_q.size()), 32'(2 * W * H));
        expect_frame("ovf_frame0", 8'h00, 0);
        expect_frame("ovf_frame1", 8'h40, W * H);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset mid-cycle with a stalled output and a partial frame pending
        rdy_level = 1'b0;
        send_frame(8'hC0, W * H);
        go_idle();
        repeat (8) @(negedge clk);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        mon_en = 1'b0;
        send_frame(8'h40, 5);
        @(posedge clk);
        #3;
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        got_q.delete();
        rdy_level = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        send_frame(8'h80, W * H);
        go_idle();
        wait_words(W * H, 60, 30);
        check("midrst_count", 32'(got_q.size()), 32'(W * H));
        expect_frame("midrst_word", 8'h80, 0);
        check("midrst_overflow_end", 32'(overflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
